// File: rtl/frv_asi_wb.sv
// Result staging buffer behind the ASI execute unit: two-entry skid FIFO with registered
// head outputs, pipeline flush and a saturating back-pressure cycle counter.
module frv_asi_wb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RDW  = 5,
    parameter int unsigned CNTW = 16
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_result,
    input  logic [RDW-1:0]  in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RDW-1:0]  out_rd,
    output logic [CNTW-1:0] stall_count
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   head_result_q, head_result_d;
    logic [RDW-1:0]    head_rd_q, head_rd_d;
    logic [XLEN-1:0]   skid_result_q, skid_result_d;
    logic [RDW-1:0]    skid_rd_q, skid_rd_d;
    logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;
    logic              push, pop;

    // Depends on state only, so upstream never sees a path from out_ready.
    assign in_ready = (state_q != StFull);

    // Writes to x0 complete the handshake but are never stored.
    assign push = in_valid && in_ready && !flush && (in_rd != '0);
    assign pop  = out_valid_q && out_ready && !flush;

    always_comb begin
        state_d       = state_q;
        head_result_d = head_result_q;
        head_rd_d     = head_rd_q;
        skid_result_d = skid_result_q;
        skid_rd_d     = skid_rd_q;
        stall_cnt_d   = stall_cnt_q;

        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d       = StOne;
                    head_result_d = in_result;
                    head_rd_d     = in_rd;
                end
            end
            StOne: begin
                if (push && pop) begin
                    head_result_d = in_result;
                    head_rd_d     = in_rd;
                end else if (push) begin
                    state_d       = StFull;
                    skid_result_d = in_result;
                    skid_rd_d     = in_rd;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    state_d       = StOne;
                    head_result_d = skid_result_q;
                    head_rd_d     = skid_rd_q;
                end
            end
            default: state_d = StEmpty;
        endcase

        // Head data is left stale on flush; only the valid state is cleared.
        if (flush) begin
            state_d = StEmpty;
        end

        out_valid_d = (state_d != StEmpty);

        if (in_valid && !in_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q       <= StEmpty;
            out_valid_q   <= 1'b0;
            head_result_q <= '0;
            head_rd_q     <= '0;
            skid_result_q <= '0;
            skid_rd_q     <= '0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            head_result_q <= head_result_d;
            head_rd_q     <= head_rd_d;
            skid_result_q <= skid_result_d;
            skid_rd_q     <= skid_rd_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = head_result_q;
    assign out_rd      = head_rd_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_frv_asi_wb.sv
// Scoreboard bench for frv_asi_wb: directed stimulus pushes expected entries, a negedge
// monitor pops and compares every accepted output.
module tb_frv_asi_wb;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic [15:0] stall_count;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } ent_t;

    ent_t exp_q[$];
    ent_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 g_clk = ~g_clk;

    frv_asi_wb #(
        .XLEN(32),
        .RDW (5),
        .CNTW(16)
    ) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_rd      (in_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .stall_count(stall_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: a transfer happens at the next posedge when valid && ready && !flush.
    always @(negedge g_clk) begin
        if (g_resetn && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(out_result), 32'hxxxx_xxxx);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_result", out_result, mon_e.res);
                chk("out_rd", 32'(out_rd), 32'(mon_e.rd));
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the posedge of the handshake.
    task automatic send(input logic [31:0] r, input logic [4:0] d);
        int   t = 0;
        ent_t e;
        in_valid  = 1'b1;
        in_result = r;
        in_rd     = d;
        @(negedge g_clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge g_clk);
        end
        if (!in_ready) begin
            chk("send_timeout", 32'(in_ready), 32'd1);
        end else if (d != 5'd0) begin
            e.res = r;
            e.rd  = d;
            exp_q.push_back(e);
        end
        @(posedge g_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge g_clk);
            t++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge g_clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge g_clk);
        #1;
    endtask

    initial begin
        g_resetn  = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_result = '0;
        in_rd     = '0;
        out_ready = 1'b0;
        cycles(3);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        g_resetn = 1'b1;
        cycles(1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single pass, one-cycle latency.
        out_ready = 1'b1;
        send(32'hDEADBEEF, 5'd5);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_result", out_result, 32'hDEADBEEF);
        chk("t1_out_rd", 32'(out_rd), 32'd5);
        cycles(1);
        chk("t1_empty", 32'(out_valid), 32'd0);

        // Back-pressure: fill, stall three cycles, then release.
        out_ready = 1'b0;
        send(32'h11, 5'd1);
        send(32'h22, 5'd2);
        in_valid  = 1'b1;
        in_result = 32'h33;
        in_rd     = 5'd3;
        chk("t2_full_in_ready", 32'(in_ready), 32'd0);
        cycles(3);
        chk("t2_stall3", 32'(stall_count), 32'd3);
        chk("t2_hold_result", out_result, 32'h11);
        out_ready = 1'b1;
        send(32'h33, 5'd3);
        drain();
        chk("t2_stall4", 32'(stall_count), 32'd4);

        // Steady stream: one push and one pop per cycle.
        for (int i = 0; i < 100; i++) begin
            send(32'h1000_0000 + 32'(i) * 32'h0101_0101, 5'(i % 31 + 1));
            chk("t3_in_ready", 32'(in_ready), 32'd1);
            chk("t3_out_valid", 32'(out_valid), 32'd1);
        end
        drain();

        // Writes to x0 are accepted and discarded.
        send(32'hFFFFFFFF, 5'd0);
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        cycles(2);
        chk("t4_out_valid_late", 32'(out_valid), 32'd0);

        // Flush a full buffer with an incoming result in the same cycle.
        out_ready = 1'b0;
        send(32'hAA, 5'd1);
        send(32'hBB, 5'd2);
        in_valid  = 1'b1;
        in_result = 32'hCC;
        in_rd     = 5'd3;
        flush     = 1'b1;
        cycles(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        chk("t5_stall", 32'(stall_count), 32'd5);
        out_ready = 1'b1;
        cycles(3);
        chk("t5_still_empty", 32'(out_valid), 32'd0);
        send(32'h55, 5'd7);
        drain();

        // Saturation, then asynchronous reset mid-stream.
        out_ready = 1'b0;
        send(32'h66, 5'd8);
        send(32'h77, 5'd9);
        in_valid  = 1'b1;
        in_result = 32'h88;
        in_rd     = 5'd10;
        cycles(70000);
        chk("t6_saturated", 32'(stall_count), 32'h0000FFFF);
        cycles(2);
        chk("t6_sat_hold", 32'(stall_count), 32'h0000FFFF);
        #2;
        g_resetn = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_out_result", out_result, 32'd0);
        chk("t6_rst_out_rd", 32'(out_rd), 32'd0);
        chk("t6_rst_stall", 32'(stall_count), 32'd0);
        chk("t6_rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        cycles(2);
        g_resetn = 1'b1;
        out_ready = 1'b1;
        cycles(3);
        chk("t6_post_rst_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
